fir_mac_seq: RTL and testbench

Time-multiplexed, parametrised FIR filter engine. It replaces a chain of per-tap combinational MAC cells with one registered signed multiplier-accumulator, a TAPS-deep sample delay line and a loadable coefficient register file. Samples enter and results leave over valid/ready handshakes. The result is rounded, shifted and saturated to the output width, and the block sits between the sample source and downstream DSP stages.

---
 rtl/fir_mac_seq.sv | 122 ++++++++++++
 tb/tb_fir_mac_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR engine: one registered signed MAC walks a TAPS-deep delay
// line against a loadable coefficient file, then rounds, shifts and saturates.
module fir_mac_seq #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  output logic                      coef_drop,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat,
  output logic                      busy
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS - 1);
  localparam logic [ACC_W-1:0] RND  = (ACC_W'(1) << SHIFT) >> 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rsum;
  logic signed [ACC_W-1:0]  r;
  logic [ACC_W-OUT_W:0]     top;
  logic                     fits;
  logic                     addr_ok;

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) && !flush;
  assign addr_ok  = (32'(coef_addr) < TAPS);

  always_comb begin
    prod = PROD_W'(x[idx]) * PROD_W'(c[idx]);
    sum  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    rsum = sum + RND;
    r    = rsum >>> SHIFT;
    // r fits in OUT_W bits only when every bit above the output sign bit matches it
    top  = r[ACC_W-1:OUT_W-1];
    fits = (top == '0) || (top == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      coef_drop <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      coef_drop <= coef_we && ((state != IDLE) || !addr_ok);
      if (coef_we && (state == IDLE) && addr_ok)
        c[coef_addr] <= coef_wdata;

      case (state)
        IDLE: begin
          if (flush) begin
            for (int unsigned k = 0; k < TAPS; k++)
              x[k] <= '0;
          end else if (in_valid) begin
            for (int unsigned k = 1; k < TAPS; k++)
              x[k] <= x[k-1];
            x[0]  <= in_data;
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            idx       <= '0;
            out_valid <= 1'b1;
            out_sat   <= !fits;
            if (fits)
              out_data <= r[OUT_W-1:0];
            else if (r[ACC_W-1])
              out_data <= {1'b1, {(OUT_W-1){1'b0}}};
            else
              out_data <= {1'b0, {(OUT_W-1){1'b1}}};
            state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: instance a is TAPS=4/SHIFT=0, instance b is
// TAPS=6/SHIFT=15 (non-power-of-two depth so an out-of-range address is encodable).
module tb_fir_mac_seq;

  logic        clk = 1'b0;
  logic        rst, sel, coef_we, flush, in_valid, out_ready;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata, in_data;

  logic        a_coef_drop, a_in_ready, a_out_valid, a_out_sat, a_busy;
  logic        b_coef_drop, b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic [15:0] a_out_data, b_out_data;

  logic        coef_drop, in_ready, out_valid, out_sat, busy;
  logic [15:0] out_data;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fir_mac_seq #(.TAPS(4), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst),
    .coef_we(coef_we & ~sel), .coef_addr(coef_addr[1:0]), .coef_wdata(coef_wdata),
    .coef_drop(a_coef_drop), .flush(flush & ~sel),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .busy(a_busy)
  );

  fir_mac_seq #(.TAPS(6), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(15)) dut_b (
    .clk(clk), .rst(rst),
    .coef_we(coef_we & sel), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_drop(b_coef_drop), .flush(flush & sel),
    .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .busy(b_busy)
  );

  assign coef_drop = sel ? b_coef_drop : a_coef_drop;
  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign out_sat   = sel ? b_out_sat   : a_out_sat;
  assign busy      = sel ? b_busy      : a_busy;
  assign out_data  = sel ? b_out_data  : a_out_data;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic start_sample(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // waits (bounded) for out_valid, counting edges since the caller's current point
  task automatic finish(input string tag, input int lat, input int exp, input int sat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check({tag, "_lat"}, n, lat);
    check({tag, "_data"}, int'($signed(out_data)), exp);
    check({tag, "_sat"}, int'(out_sat), sat);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    check({tag, "_vld_low"}, int'(out_valid), 0);
    check({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  task automatic run_sample(input string tag, input logic [15:0] d, input int exp, input int sat);
    start_sample(d);
    finish(tag, sel ? 6 : 4, exp, sat);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] sat_in [10] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    int          sat_exp [10] = '{32767, 32767, 32767, 32767, 32767,
                                  32767, -32768, -32768, -32768, -32768};
    int          imp_exp [5]  = '{1, 2, 3, 4, 0};
    logic [15:0] imp_in  [5]  = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};

    rst = 1'b1; sel = 1'b0; coef_we = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; coef_addr = '0; coef_wdata = '0; in_data = '0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sat", int'(out_sat), 0);
    check("rst_drop", int'(coef_drop), 0);
    rst = 1'b0;
    @(negedge clk);

    // impulse response on the 4-tap instance
    for (int k = 0; k < 4; k++) wr_coef(3'(k), 16'(k + 1));
    check("wr_no_drop", int'(coef_drop), 0);
    for (int i = 0; i < 5; i++) run_sample($sformatf("imp%0d", i), imp_in[i], imp_exp[i], 0);

    for (int k = 0; k < 4; k++) wr_coef(3'(k), 16'h7FFF);
    for (int i = 0; i < 10; i++) run_sample($sformatf("sat%0d", i), sat_in[i], sat_exp[i], 1);

    // flush beats a simultaneous sample
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd99;
    #1 check("flush_in_ready", int'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_not_accepted", int'(busy), 0);
    wr_coef(3'd0, 16'd3);

    out_ready = 1'b0;
    start_sample(16'd5);
    finish("bp", 4, 15, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), int'($signed(out_data)), 15);
    end
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_busy", int'(busy), 1);
    check("bp_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    handshake("bp_rel");
    check("bp_idle", int'(busy), 0);

    // coefficient write while the MAC is running must be dropped
    flush_cycle();
    start_sample(16'd2);
    wr_coef(3'd0, 16'd100);
    check("mac_drop_pulse", int'(coef_drop), 1);
    @(negedge clk);
    check("mac_drop_once", int'(coef_drop), 0);
    finish("mac_wr", 2, 6, 0);
    handshake("mac_wr");
    flush_cycle();
    run_sample("c0_kept", 16'd1, 3, 0);

    // write and sample in the same cycle: new coefficient applies
    flush_cycle();
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'd7;
    in_valid = 1'b1; in_data = 16'd2;
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0;
    check("same_cyc_drop", int'(coef_drop), 0);
    finish("same_cyc", 4, 14, 0);
    handshake("same_cyc");

    // reset mid-MAC
    start_sample(16'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    run_sample("post_rst_zero", 16'd1, 0, 0);

    // 6-tap instance: out-of-range address, then rounding
    sel = 1'b1;
    #1 check("b_idle", int'(in_ready), 1);
    wr_coef(3'd6, 16'h4000);
    check("oor_drop", int'(coef_drop), 1);
    @(negedge clk);
    check("oor_drop_once", int'(coef_drop), 0);
    flush_cycle();
    wr_coef(3'd0, 16'h4000);
    run_sample("rnd_pos", 16'd3, 2, 0);
    flush_cycle();
    run_sample("rnd_neg", 16'hFFFD, -1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
